// File: rtl/hazard_if.sv
// ID-stage decode fields into the hazard unit and the pipeline control it drives back.
interface hazard_if;
    logic       rs1use;
    logic       rs2use;
    logic [1:0] hazard_optype;
    logic [4:0] rd_ID;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       Branch_ID;
    logic [1:0] forward_ctrl_A;
    logic [1:0] forward_ctrl_B;
    logic       forward_ctrl_ls;
    logic       PC_EN_IF;
    logic       reg_FD_EN;
    logic       reg_FD_flush;
    logic       reg_DE_flush;
    logic       reg_EM_EN;
    logic       reg_MW_EN;

    modport master (
        output rs1use, rs2use, hazard_optype, rd_ID, rs1_ID, rs2_ID, Branch_ID,
        input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
               reg_FD_flush, reg_DE_flush, reg_EM_EN, reg_MW_EN
    );

    modport slave (
        input  rs1use, rs2use, hazard_optype, rd_ID, rs1_ID, rs2_ID, Branch_ID,
        output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
               reg_FD_flush, reg_DE_flush, reg_EM_EN, reg_MW_EN
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: shadows in-flight writers through
// EX/MEM/WB and drives forwarding selects, the one-cycle load-use stall and taken-branch flush.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_if.slave          hz,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [1:0] FWD_RF       = 2'b00;
    localparam logic [1:0] FWD_EX_ALU   = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
    localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

    logic [1:0]       optypeEx_q, optypeEx_d;
    logic [4:0]       rdEx_q, rdEx_d;
    logic [4:0]       rs2Ex_q, rs2Ex_d;
    logic [1:0]       optypeMem_q, optypeMem_d;
    logic [4:0]       rdMem_q, rdMem_d;
    logic [4:0]       rs2Mem_q, rs2Mem_d;
    logic [1:0]       optypeWb_q, optypeWb_d;
    logic [4:0]       rdWb_q, rdWb_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic writerEx, writerMem;
    logic match1Ex, match2Ex, match1Mem, match2Mem;
    logic loadUse;

    function automatic logic isWriter(input logic [1:0] op, input logic [4:0] rd);
        return ((op == OP_ALU) || (op == OP_LOAD)) && (rd != 5'd0);
    endfunction

    // Youngest producer wins; a load still in EX cannot forward and is covered by the stall.
    function automatic logic [1:0] fwdSel(input logic matchEx, input logic [1:0] opEx,
                                          input logic matchMem, input logic [1:0] opMem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (matchEx && (opEx == OP_ALU)) begin
            sel = FWD_EX_ALU;
        end else if (matchMem) begin
            sel = (opMem == OP_LOAD) ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
        return sel;
    endfunction

    always_comb begin
        writerEx  = isWriter(optypeEx_q, rdEx_q);
        writerMem = isWriter(optypeMem_q, rdMem_q);
        match1Ex  = hz.rs1use && writerEx  && (rdEx_q  == hz.rs1_ID);
        match2Ex  = hz.rs2use && writerEx  && (rdEx_q  == hz.rs2_ID);
        match1Mem = hz.rs1use && writerMem && (rdMem_q == hz.rs1_ID);
        match2Mem = hz.rs2use && writerMem && (rdMem_q == hz.rs2_ID);
        // Store data alone does not stall: the WB load result is steered into MEM later.
        loadUse   = (optypeEx_q == OP_LOAD) &&
                    (match1Ex || (match2Ex && (hz.hazard_optype != OP_STORE)));
    end

    always_comb begin
        hz.forward_ctrl_A  = fwdSel(match1Ex, optypeEx_q, match1Mem, optypeMem_q);
        hz.forward_ctrl_B  = fwdSel(match2Ex, optypeEx_q, match2Mem, optypeMem_q);
        hz.forward_ctrl_ls = (optypeMem_q == OP_STORE) && (optypeWb_q == OP_LOAD) &&
                             (rdWb_q != 5'd0) && (rdWb_q == rs2Mem_q);
        hz.PC_EN_IF        = 1'b1;
        hz.reg_FD_EN       = 1'b1;
        hz.reg_FD_flush    = 1'b0;
        hz.reg_DE_flush    = 1'b0;
        hz.reg_EM_EN       = 1'b1;
        hz.reg_MW_EN       = 1'b1;
        if (loadUse) begin
            hz.PC_EN_IF     = 1'b0;
            hz.reg_FD_EN    = 1'b0;
            hz.reg_DE_flush = 1'b1;
        end else if (hz.Branch_ID) begin
            hz.reg_FD_flush = 1'b1;
        end
    end

    always_comb begin
        optypeEx_d  = loadUse ? OP_NONE : hz.hazard_optype;
        rdEx_d      = hz.rd_ID;
        rs2Ex_d     = hz.rs2_ID;
        optypeMem_d = optypeEx_q;
        rdMem_d     = rdEx_q;
        rs2Mem_d    = rs2Ex_q;
        optypeWb_d  = optypeMem_q;
        rdWb_d      = rdMem_q;
        stallCnt_d  = stallCnt_q + {{(CNT_W-1){1'b0}}, loadUse};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            optypeEx_q  <= OP_NONE;
            rdEx_q      <= 5'd0;
            rs2Ex_q     <= 5'd0;
            optypeMem_q <= OP_NONE;
            rdMem_q     <= 5'd0;
            rs2Mem_q    <= 5'd0;
            optypeWb_q  <= OP_NONE;
            rdWb_q      <= 5'd0;
            stallCnt_q  <= '0;
        end else begin
            optypeEx_q  <= optypeEx_d;
            rdEx_q      <= rdEx_d;
            rs2Ex_q     <= rs2Ex_d;
            optypeMem_q <= optypeMem_d;
            rdMem_q     <= rdMem_d;
            rs2Mem_q    <= rs2Mem_d;
            optypeWb_q  <= optypeWb_d;
            rdWb_q      <= rdWb_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a queue-based model of the in-flight instructions predicts each
// cycle's control outputs, a negedge monitor pops and compares.
module tb_hazard_unit;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] stallCnt;

    hazard_if hzIf();

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (hzIf),
        .stall_cnt_o (stallCnt)
    );

    typedef struct {
        logic [1:0] op;
        logic [4:0] rd;
        logic [4:0] rs2;
    } inflight_t;

    typedef struct {
        logic [1:0]       fwdA;
        logic [1:0]       fwdB;
        logic             fwdLs;
        logic             pcEn;
        logic             fdEn;
        logic             fdFlush;
        logic             deFlush;
        logic [CNT_W-1:0] cnt;
    } expect_t;

    inflight_t pipe [3];
    int        modelStalls;
    logic      modelStall;
    expect_t   sbQ [$];
    int        compared   = 0;
    int        mismatched = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic writes(input inflight_t e, input logic [4:0] r);
        return ((e.op == 2'b01) || (e.op == 2'b10)) && (e.rd != 5'd0) && (e.rd == r);
    endfunction

    function automatic logic [1:0] sourceFor(input logic used, input logic [4:0] r,
                                             input inflight_t ex, input inflight_t mem);
        if (!used) return 2'b00;
        if (writes(ex, r) && (ex.op == 2'b01)) return 2'b01;
        if (writes(mem, r)) return (mem.op == 2'b10) ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 3; i++) pipe[i] = '{2'b00, 5'd0, 5'd0};
        modelStalls = 0;
    endtask

    task automatic computeExpected();
        expect_t e;
        logic    useEx1, useEx2;
        useEx1     = hzIf.rs1use && writes(pipe[0], hzIf.rs1_ID);
        useEx2     = hzIf.rs2use && writes(pipe[0], hzIf.rs2_ID);
        modelStall = (pipe[0].op == 2'b10) && (useEx1 || (useEx2 && (hzIf.hazard_optype != 2'b11)));
        e.fwdA     = sourceFor(hzIf.rs1use, hzIf.rs1_ID, pipe[0], pipe[1]);
        e.fwdB     = sourceFor(hzIf.rs2use, hzIf.rs2_ID, pipe[0], pipe[1]);
        e.fwdLs    = (pipe[1].op == 2'b11) && (pipe[2].op == 2'b10) &&
                     (pipe[2].rd != 5'd0) && (pipe[2].rd == pipe[1].rs2);
        e.pcEn     = !modelStall;
        e.fdEn     = !modelStall;
        e.deFlush  = modelStall;
        e.fdFlush  = !modelStall && hzIf.Branch_ID;
        e.cnt      = modelStalls[CNT_W-1:0];
        sbQ.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic applyStimulus(input logic r1u, input logic r2u, input logic [1:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic br, input bit midReset);
        hzIf.rs1use        = r1u;
        hzIf.rs2use        = r2u;
        hzIf.hazard_optype = op;
        hzIf.rd_ID         = rd;
        hzIf.rs1_ID        = rs1;
        hzIf.rs2_ID        = rs2;
        hzIf.Branch_ID     = br;
        if (midReset) begin
            #2;
            rst_n = 1'b0;
            resetModel();
        end
        computeExpected();
        @(posedge clk);
        if (rst_n) begin
            pipe[2]     = pipe[1];
            pipe[1]     = pipe[0];
            pipe[0]     = '{(modelStall ? 2'b00 : op), rd, rs2};
            modelStalls = (modelStalls + (modelStall ? 1 : 0)) % (1 << CNT_W);
        end
        #1;
        if (!rst_n) rst_n = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("forward_ctrl_A",  32'(hzIf.forward_ctrl_A),  32'(e.fwdA));
                checkOutput("forward_ctrl_B",  32'(hzIf.forward_ctrl_B),  32'(e.fwdB));
                checkOutput("forward_ctrl_ls", 32'(hzIf.forward_ctrl_ls), 32'(e.fwdLs));
                checkOutput("PC_EN_IF",        32'(hzIf.PC_EN_IF),        32'(e.pcEn));
                checkOutput("reg_FD_EN",       32'(hzIf.reg_FD_EN),       32'(e.fdEn));
                checkOutput("reg_FD_flush",    32'(hzIf.reg_FD_flush),    32'(e.fdFlush));
                checkOutput("reg_DE_flush",    32'(hzIf.reg_DE_flush),    32'(e.deFlush));
                checkOutput("reg_EM_EN",       32'(hzIf.reg_EM_EN),       32'd1);
                checkOutput("reg_MW_EN",       32'(hzIf.reg_MW_EN),       32'd1);
                checkOutput("stall_cnt",       32'(stallCnt),             32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        hzIf.rs1use        = 1'b0;
        hzIf.rs2use        = 1'b0;
        hzIf.hazard_optype = 2'b00;
        hzIf.rd_ID         = 5'd0;
        hzIf.rs1_ID        = 5'd0;
        hzIf.rs2_ID        = 5'd0;
        hzIf.Branch_ID     = 1'b0;
        resetModel();
        @(posedge clk);
        #1;
        $display("[TB] reset state, branch while in reset");
        applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] ALU forwarding EX then MEM");
        applyStimulus(1'b0, 1'b0, 2'b01, 5'd5,  5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd9,  5'd5, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 5'd0,  5'd5, 5'd0, 1'b0, 1'b0);

        $display("[TB] load-use stall then MEM load forward");
        applyStimulus(1'b1, 1'b0, 2'b10, 5'd6,  5'd1, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 5'd10, 5'd0, 5'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 5'd10, 5'd0, 5'd6, 1'b0, 1'b0);

        $display("[TB] load then store data dependency");
        applyStimulus(1'b0, 1'b0, 2'b10, 5'd7,  5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 5'd0,  5'd2, 5'd7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("[TB] x0 never forwards");
        applyStimulus(1'b0, 1'b0, 2'b01, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0);

        $display("[TB] load-use with branch in same cycle");
        applyStimulus(1'b0, 1'b0, 2'b10, 5'd6,  5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 5'd0,  5'd6, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 5'd0,  5'd6, 5'd0, 1'b1, 1'b0);

        $display("[TB] reset asserted mid-stall");
        applyStimulus(1'b0, 1'b0, 2'b10, 5'd6,  5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 5'd3,  5'd0, 5'd6, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b01, 5'd3,  5'd0, 5'd6, 1'b0, 1'b0);

        $display("[TB] sixteen stalls wrap the counter");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b10, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 2'b01, 5'd4, 5'd6, 5'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (sbQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
